// File: rtl/ntt_ld_streamer.sv
// Load-side streamer for the NTT kernel: reads the twiddle table, then the polynomial in
// interleaved low/high order, and presents both as valid/ready streams from a 2-entry prefetch FIFO.
module ntt_ld_streamer #(
  parameter int unsigned pDATA_WIDTH = 128,
  parameter int unsigned pADDR_WIDTH = 11,
  parameter int unsigned pNUM_WORDS  = 128,
  parameter int unsigned pNUM_COEF   = 64,
  parameter int unsigned pLD_GAP     = 7
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic [pADDR_WIDTH-1:0] cfg_coef_base,
  input  logic [pADDR_WIDTH-1:0] cfg_data_base,
  output logic                   busy,
  output logic                   done,
  output logic                   mem_en,
  output logic [pADDR_WIDTH-1:0] mem_addr,
  input  logic [pDATA_WIDTH-1:0] mem_rdata,
  output logic                   coef_vld,
  input  logic                   coef_rdy,
  output logic [pDATA_WIDTH-1:0] coef_dat,
  output logic                   ld_vld,
  input  logic                   ld_rdy,
  output logic [pDATA_WIDTH-1:0] ld_dat,
  output logic                   ld_lst
);

  localparam int unsigned Half = pNUM_WORDS / 2;
  localparam int unsigned CCW  = $clog2(pNUM_COEF + 1);
  localparam int unsigned DCW  = $clog2(pNUM_WORDS + 1);
  localparam int unsigned GCW  = (pLD_GAP > 1) ? $clog2(pLD_GAP) : 1;

  typedef enum logic [2:0] {StIdle, StCoef, StData, StGap, StDone} state_e;

  state_e                 state_q, state_d;
  logic [pADDR_WIDTH-1:0] coef_base_q, data_base_q;
  logic [CCW-1:0]         coef_rd_q, coef_tx_q;
  logic [DCW-1:0]         data_rd_q, data_tx_q;
  logic [GCW-1:0]         gap_q;
  logic                   inflight_q;
  logic [pDATA_WIDTH-1:0] fifo_q [2];
  logic                   wr_ptr_q, rd_ptr_q;
  logic [1:0]             occ_q;
  logic [pDATA_WIDTH-1:0] coef_hold_q, ld_hold_q;

  logic                   active, have, coef_hs, ld_hs, pop, room;
  logic                   owed_coef, owed_data, start_acc;
  logic [pDATA_WIDTH-1:0] head;
  logic [pADDR_WIDTH-1:0] data_off, rd_addr;

  always_comb begin
    active    = (state_q == StCoef) || (state_q == StData) || (state_q == StGap);
    have      = (occ_q != 2'd0);
    head      = fifo_q[rd_ptr_q];
    coef_vld  = (state_q == StCoef) && have;
    ld_vld    = (state_q == StData) && have;
    coef_hs   = coef_vld && coef_rdy;
    ld_hs     = ld_vld && ld_rdy;
    pop       = coef_hs || ld_hs;
    start_acc = (state_q == StIdle) && start;
    owed_coef = coef_rd_q < CCW'(pNUM_COEF);
    // Data reads wait for the last coef read so the FIFO never holds data ahead of coef.
    owed_data = !owed_coef && (data_rd_q < DCW'(pNUM_WORDS));
    // A same-cycle pop frees a slot, which keeps the coef stream free of bubbles.
    room      = ({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
    mem_en    = active && room && (owed_coef || owed_data);
    data_off  = pADDR_WIDTH'(data_rd_q >> 1) + (data_rd_q[0] ? pADDR_WIDTH'(Half) : '0);
    rd_addr   = owed_coef ? coef_base_q + pADDR_WIDTH'(coef_rd_q) : data_base_q + data_off;
    mem_addr  = mem_en ? rd_addr : '0;
    coef_dat  = coef_vld ? head : coef_hold_q;
    ld_dat    = ld_vld ? head : ld_hold_q;
    ld_lst    = ld_vld && (data_tx_q == DCW'(pNUM_WORDS - 1));
    busy      = active;
    done      = (state_q == StDone);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StCoef;
      StCoef: if (coef_hs && (coef_tx_q == CCW'(pNUM_COEF - 1))) state_d = StData;
      StData: begin
        if (ld_hs) begin
          if (ld_lst)            state_d = StDone;
          else if (pLD_GAP != 0) state_d = StGap;
        end
      end
      StGap:  if (gap_q == GCW'(pLD_GAP - 1)) state_d = StData;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q     <= StIdle;
      coef_base_q <= '0;
      data_base_q <= '0;
      coef_rd_q   <= '0;
      coef_tx_q   <= '0;
      data_rd_q   <= '0;
      data_tx_q   <= '0;
      gap_q       <= '0;
      inflight_q  <= 1'b0;
      fifo_q[0]   <= '0;
      fifo_q[1]   <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      occ_q       <= 2'd0;
      coef_hold_q <= '0;
      ld_hold_q   <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= mem_en;
      gap_q      <= (state_q == StGap) ? gap_q + GCW'(1) : '0;
      if (start_acc) begin
        coef_base_q <= cfg_coef_base;
        data_base_q <= cfg_data_base;
        coef_rd_q   <= '0;
        coef_tx_q   <= '0;
        data_rd_q   <= '0;
        data_tx_q   <= '0;
      end else begin
        if (mem_en && owed_coef) coef_rd_q <= coef_rd_q + CCW'(1);
        if (mem_en && owed_data) data_rd_q <= data_rd_q + DCW'(1);
        if (coef_hs)             coef_tx_q <= coef_tx_q + CCW'(1);
        if (ld_hs)               data_tx_q <= data_tx_q + DCW'(1);
      end
      if (inflight_q) begin
        fifo_q[wr_ptr_q] <= mem_rdata;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_q + {1'b0, inflight_q} - {1'b0, pop};
      if (coef_vld) coef_hold_q <= head;
      if (ld_vld)   ld_hold_q   <= head;
    end
  end

endmodule

// File: tb/tb_ntt_ld_streamer.sv
// Self-checking bench for ntt_ld_streamer: default configuration plus a small no-gap variant,
// checked against an address-order reference model and a behavioural memory.
module tb_ntt_ld_streamer;
  localparam int DW = 128;
  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] cfg_coef_base = '0, cfg_data_base = '0;
  logic          busy, done, mem_en, coef_vld, ld_vld, ld_lst;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0, coef_dat, ld_dat;
  logic          coef_rdy = 1'b1, ld_rdy = 1'b1;

  logic          start_v = 1'b0;
  logic [AW-1:0] cb_v = 11'h010, db_v = 11'h020;
  logic          busy_v, done_v, mem_en_v, coef_vld_v, ld_vld_v, ld_lst_v;
  logic [AW-1:0] mem_addr_v;
  logic [DW-1:0] mem_rdata_v = '0, coef_dat_v, ld_dat_v;

  int unsigned vectors = 0, errors = 0;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ntt_ld_streamer u_dut (
    .clk(clk), .rstn(rstn), .start(start), .cfg_coef_base(cfg_coef_base),
    .cfg_data_base(cfg_data_base), .busy(busy), .done(done), .mem_en(mem_en),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .coef_vld(coef_vld), .coef_rdy(coef_rdy),
    .coef_dat(coef_dat), .ld_vld(ld_vld), .ld_rdy(ld_rdy), .ld_dat(ld_dat), .ld_lst(ld_lst)
  );

  ntt_ld_streamer #(.pNUM_WORDS(8), .pNUM_COEF(4), .pLD_GAP(0)) u_var (
    .clk(clk), .rstn(rstn), .start(start_v), .cfg_coef_base(cb_v), .cfg_data_base(db_v),
    .busy(busy_v), .done(done_v), .mem_en(mem_en_v), .mem_addr(mem_addr_v),
    .mem_rdata(mem_rdata_v), .coef_vld(coef_vld_v), .coef_rdy(1'b1), .coef_dat(coef_dat_v),
    .ld_vld(ld_vld_v), .ld_rdy(1'b1), .ld_dat(ld_dat_v), .ld_lst(ld_lst_v)
  );

  // Memory word w holds 16-bit lanes 8w+7 .. 8w (lane 0 in the low bits).
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    logic [DW-1:0] w;
    for (int j = 0; j < 8; j++) w[16*j +: 16] = 16'({a, 3'b000} + j);
    return w;
  endfunction

  always @(posedge clk) if (mem_en) mem_rdata <= mem_word(mem_addr);
  always @(posedge clk) if (mem_en_v) mem_rdata_v <= mem_word(mem_addr_v);

  logic [DW-1:0] coef_obs[$], ld_obs[$], coef_obs_v[$], ld_obs_v[$];
  int            coef_t[$], ld_t[$], done_t[$], ld_t_v[$], done_t_v[$];
  bit            lst_obs[$], lst_obs_v[$];
  int            first_vld_t = -1;
  bit            prev_cs = 0, prev_ls = 0;
  logic [DW-1:0] prev_cd, prev_ld;
  int            issued = 0, popped = 0;

  always @(negedge clk) begin
    if (rstn) begin
      prev_cs = 0; prev_ls = 0; issued = 0; popped = 0;
    end else begin
      if (prev_cs) begin
        vectors++;
        if (coef_vld !== 1'b1 || coef_dat !== prev_cd) begin
          errors++; $display("FAIL coef_stable t=%0d vld=%b dat=%h want %h", cyc, coef_vld, coef_dat, prev_cd);
        end
      end
      if (prev_ls) begin
        vectors++;
        if (ld_vld !== 1'b1 || ld_dat !== prev_ld) begin
          errors++; $display("FAIL ld_stable t=%0d vld=%b dat=%h want %h", cyc, ld_vld, ld_dat, prev_ld);
        end
      end
      prev_cs = coef_vld && !coef_rdy; prev_cd = coef_dat;
      prev_ls = ld_vld && !ld_rdy;     prev_ld = ld_dat;
      if (mem_en) issued++;
      if ((coef_vld && coef_rdy) || (ld_vld && ld_rdy)) popped++;
      if (mem_en) begin
        vectors++;
        if (issued - popped > 2) begin
          errors++; $display("FAIL outstanding t=%0d got %0d max 2", cyc, issued - popped);
        end
      end
      if (ld_lst && !ld_vld) begin
        errors++; $display("FAIL lst_without_vld t=%0d got lst=1 want 0", cyc);
      end
      if (coef_vld && first_vld_t < 0) first_vld_t = cyc;
      if (coef_vld && coef_rdy) begin coef_obs.push_back(coef_dat); coef_t.push_back(cyc); end
      if (ld_vld && ld_rdy) begin
        ld_obs.push_back(ld_dat); ld_t.push_back(cyc); lst_obs.push_back(ld_lst);
      end
      if (done) done_t.push_back(cyc);
      if (coef_vld_v) coef_obs_v.push_back(coef_dat_v);
      if (ld_vld_v) begin ld_obs_v.push_back(ld_dat_v); ld_t_v.push_back(cyc); lst_obs_v.push_back(ld_lst_v); end
      if (done_v) done_t_v.push_back(cyc);
    end
  end

  task automatic run_xfer(input logic [AW-1:0] cb, input logic [AW-1:0] db, input bit bp,
                          input bit dup_start, input int budget, output int start_t,
                          output bit timed_out);
    coef_obs.delete(); coef_t.delete(); ld_obs.delete(); ld_t.delete();
    lst_obs.delete(); done_t.delete(); first_vld_t = -1;
    @(posedge clk); #1;
    cfg_coef_base = cb; cfg_data_base = db; start = 1'b1; start_t = cyc;
    coef_rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    ld_rdy   = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble the config inputs: the bases must have been latched at start.
    cfg_coef_base = AW'($urandom); cfg_data_base = AW'($urandom);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (done_t.size() > 0) begin timed_out = 1'b0; break; end
      @(posedge clk); #1;
      if (bp) begin coef_rdy = 1'($urandom_range(0, 1)); ld_rdy = 1'($urandom_range(0, 1)); end
      start = dup_start && (i == 20 || i == 300);
    end
    start = 1'b0; coef_rdy = 1'b1; ld_rdy = 1'b1;
  endtask

  task automatic test_stream(input string name, input logic [AW-1:0] cb, input logic [AW-1:0] db,
                             input bit bp, input bit dup_start, output int start_t);
    bit            to;
    logic [AW-1:0] exp_a[$];
    logic [AW-1:0] a;
    run_xfer(cb, db, bp, dup_start, 8000, start_t, to);
    vectors++;
    if (to) begin errors++; $display("FAIL %s timeout got no done within budget", name); end
    for (int i = 0; i < 64; i++) begin
      a = AW'(db + i);      exp_a.push_back(a);
      a = AW'(db + 64 + i); exp_a.push_back(a);
    end
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (coef_obs.size() != 64 || ld_obs.size() != 128 || done_t.size() != 1) begin
      errors++;
      $display("FAIL %s counts got coef=%0d ld=%0d done=%0d want 64/128/1", name,
               coef_obs.size(), ld_obs.size(), done_t.size());
    end
    for (int c = 0; c < coef_obs.size() && c < 64; c++) begin
      a = AW'(cb + c);
      vectors++;
      if (coef_obs[c] !== mem_word(a)) begin
        errors++; $display("FAIL %s coef[%0d] got %h want %h", name, c, coef_obs[c], mem_word(a));
      end
    end
    for (int k = 0; k < ld_obs.size() && k < 128; k++) begin
      vectors++;
      if (ld_obs[k] !== mem_word(exp_a[k]) || lst_obs[k] !== (k == 127)) begin
        errors++;
        $display("FAIL %s ld[%0d] got %h lst=%b want %h lst=%b", name, k, ld_obs[k], lst_obs[k],
                 mem_word(exp_a[k]), k == 127);
      end
    end
    vectors++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_after got %b want 0", name, busy); end
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({busy, done, mem_en, coef_vld, ld_vld, ld_lst} !== 6'b0 || mem_addr !== '0 ||
        coef_dat !== '0 || ld_dat !== '0) begin
      errors++; $display("FAIL reset_outputs got busy=%b done=%b en=%b cv=%b lv=%b want all 0",
                         busy, done, mem_en, coef_vld, ld_vld);
    end
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0 || mem_en !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset got busy=%b en=%b want 0 0", busy, mem_en);
    end
  endtask

  task automatic test_basic();
    int st;
    test_stream("basic", 11'h200, 11'h000, 1'b0, 1'b0, st);
    // Start high in the cycle sampled at edge T; coef_vld is seen in the cycle after edge T+2.
    vectors++;
    if (first_vld_t - st != 3) begin
      errors++; $display("FAIL first_coef_latency got %0d want 3", first_vld_t - st);
    end
    for (int c = 1; c < coef_t.size(); c++) begin
      vectors++;
      if (coef_t[c] - coef_t[c-1] != 1) begin
        errors++; $display("FAIL coef_bubble beat %0d got gap %0d want 1", c, coef_t[c] - coef_t[c-1]);
      end
    end
    vectors++;
    if (coef_t.size() > 0 && coef_t[0] != first_vld_t) begin
      errors++; $display("FAIL coef_first_hs got %0d want %0d", coef_t[0], first_vld_t);
    end
    for (int k = 1; k < ld_t.size(); k++) begin
      vectors++;
      if (ld_t[k] - ld_t[k-1] != 8) begin
        errors++; $display("FAIL ld_pacing beat %0d got %0d want 8", k, ld_t[k] - ld_t[k-1]);
      end
    end
    vectors++;
    if (ld_t.size() == 0 || done_t.size() == 0 || done_t[0] - ld_t[ld_t.size()-1] != 1) begin
      errors++; $display("FAIL done_timing got done=%0d ld=%0d want 1 cycle after last ld",
                         done_t.size(), ld_t.size());
    end
  endtask

  task automatic test_backpressure();
    int st;
    test_stream("bp1", 11'h155, 11'h3A0, 1'b1, 1'b0, st);
    test_stream("bp2", 11'h7F0, 11'h011, 1'b1, 1'b0, st);
  endtask

  task automatic test_wrap();
    int st;
    test_stream("wrap", 11'h100, 11'h7C0, 1'b0, 1'b0, st);
    vectors++;
    if (ld_obs.size() < 2 || ld_obs[1] !== mem_word(11'h000)) begin
      errors++; $display("FAIL wrap_beat1 got size=%0d want beat1 = word 0x000", ld_obs.size());
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    int st;
    run_xfer(11'h200, 11'h000, 1'b0, 1'b0, 0, st, to);
    to = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (ld_obs.size() >= 10) begin to = 1'b0; break; end
      @(posedge clk); #1;
    end
    vectors++;
    if (to) begin errors++; $display("FAIL mid_reset_wait got %0d ld beats want 10", ld_obs.size()); end
    rstn = 1'b1;
    #1;
    vectors++;
    if ({busy, done, mem_en, coef_vld, ld_vld, ld_lst} !== 6'b0 || mem_addr !== '0 ||
        coef_dat !== '0 || ld_dat !== '0) begin
      errors++; $display("FAIL mid_reset_outputs got busy=%b done=%b en=%b lv=%b want all 0",
                         busy, done, mem_en, ld_vld);
    end
    repeat (2) @(posedge clk);
    #1 rstn = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    vectors++;
    if (done_t.size() != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_reset_no_done got done=%0d busy=%b want 0 0", done_t.size(), busy);
    end
    test_stream("replay", 11'h200, 11'h000, 1'b0, 1'b1, st);
  endtask

  task automatic test_variant();
    int order [8];
    bit to;
    logic [AW-1:0] a;
    order = '{0, 4, 1, 5, 2, 6, 3, 7};
    coef_obs_v.delete(); ld_obs_v.delete(); ld_t_v.delete(); lst_obs_v.delete(); done_t_v.delete();
    @(posedge clk); #1 start_v = 1'b1;
    @(posedge clk); #1 start_v = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (done_t_v.size() > 0) begin to = 1'b0; break; end
      @(posedge clk); #1;
    end
    vectors++;
    if (to || coef_obs_v.size() != 4 || ld_obs_v.size() != 8) begin
      errors++; $display("FAIL var_counts got coef=%0d ld=%0d to=%b want 4/8/0",
                         coef_obs_v.size(), ld_obs_v.size(), to);
    end
    for (int c = 0; c < coef_obs_v.size() && c < 4; c++) begin
      a = AW'(cb_v + c);
      vectors++;
      if (coef_obs_v[c] !== mem_word(a)) begin
        errors++; $display("FAIL var_coef[%0d] got %h want %h", c, coef_obs_v[c], mem_word(a));
      end
    end
    for (int k = 0; k < ld_obs_v.size() && k < 8; k++) begin
      a = AW'(db_v + order[k]);
      vectors++;
      if (ld_obs_v[k] !== mem_word(a) || lst_obs_v[k] !== (k == 7)) begin
        errors++; $display("FAIL var_ld[%0d] got %h lst=%b want %h lst=%b", k, ld_obs_v[k],
                           lst_obs_v[k], mem_word(a), k == 7);
      end
      if (k > 0) begin
        vectors++;
        if (ld_t_v[k] - ld_t_v[k-1] != 1) begin
          errors++; $display("FAIL var_b2b beat %0d got gap %0d want 1", k, ld_t_v[k] - ld_t_v[k-1]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_variant();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
